sobel_grad_sq: RTL and testbench

- Streaming Sobel front end that feeds squareroot_AHSQR_k6.
- Accepts 8-bit grayscale pixels in raster order and builds 3x3 windows from two line buffers.
- Computes Gx and Gy, scales them, and emits the 16-bit radicand Gx²+Gy² for each interior pixel.
- Valid/ready handshake on both sides; 3-stage pipeline.

---
 rtl/sobel_pkg.sv | 27 ++
 rtl/sobel_line_buf.sv | 47 ++++
 rtl/sobel_grad_sq.sv | 219 +++++++++++++++++++++
 tb/tb_sobel_grad_sq.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// ----------------------------------------------------------------------------
// sobel_pkg
// Shared types and constants for the Sobel gradient-squared front end.
//   pix_t  : 8-bit grayscale pixel
//   grad_t : signed 11-bit Sobel gradient (range -1020..+1020)
//   mag_t  : 10-bit scaled gradient magnitude
//   rad_t  : 16-bit radicand handed to the square-root unit
// ----------------------------------------------------------------------------
package sobel_pkg;

    localparam int GRAD_W = 11;

    typedef logic        [7:0]        pix_t;
    typedef logic signed [GRAD_W-1:0] grad_t;
    typedef logic        [9:0]        mag_t;
    typedef logic        [15:0]       rad_t;

    localparam rad_t RAD_MAX = 16'hFFFF;

    // |g| >> sh. |g| never exceeds 1020, so the 10-bit result cannot overflow.
    function automatic mag_t abs_shift(input grad_t g, input int unsigned sh);
        logic [GRAD_W-1:0] m;
        m = g[GRAD_W-1] ? GRAD_W'(-g) : GRAD_W'(g);
        return mag_t'(m >> sh);
    endfunction

endpackage

// File: rtl/sobel_line_buf.sv
// ----------------------------------------------------------------------------
// sobel_line_buf
// DEPTH-entry circular delay line: dout is the pixel written DEPTH writes ago.
// The read is taken from the slot about to be overwritten, so a write and the
// matching read happen on the same transfer.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset (pointer only, RAM is not cleared)
//   we    : write/advance strobe (one per accepted pixel)
//   din   : pixel entering the line
//   dout  : pixel leaving the line (one line older)
// ----------------------------------------------------------------------------
module sobel_line_buf
    import sobel_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       we,
    input  logic [7:0] din,
    output logic [7:0] dout
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    pix_t          mem [DEPTH];
    logic [AW-1:0] ptr_q;

    assign dout = mem[ptr_q];

    // Storage is intentionally not reset: the row/col counters mask stale data.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[ptr_q] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else if (we) begin
            ptr_q <= (ptr_q == AW'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
        end
    end

endmodule

// File: rtl/sobel_grad_sq.sv
// ----------------------------------------------------------------------------
// sobel_grad_sq
// Streaming Sobel front end: builds 3x3 windows from two chained line buffers,
// computes Gx/Gy, scales by GSHIFT and emits the saturated radicand
// Gx^2+Gy^2 for every interior pixel. Three-stage pipeline with valid/ready
// on both sides; the whole pipe stalls when the output is held.
// Optional feature macro: SOBEL_GRAD_SAT_FLAG_EN adds out_sat (clamp applied).
// Ports:
//   clk, rst_n           : clock / asynchronous active-low reset
//   in_valid/in_ready    : input handshake
//   in_pix               : 8-bit grayscale pixel, raster order
//   in_sof               : first pixel of frame (forces position 0,0)
//   out_valid/out_ready  : output handshake
//   out_rad              : min(Gx^2+Gy^2, 16'hFFFF)
//   out_eol / out_eof    : last interior pixel of line / of frame
//   out_sat              : (macro only) clamp was applied to out_rad
// ----------------------------------------------------------------------------
module sobel_grad_sq
    import sobel_pkg::*;
#(
    parameter int IMG_W  = 64,
    parameter int IMG_H  = 64,
    parameter int GSHIFT = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_pix,
    input  logic        in_sof,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_rad,
    output logic        out_eol,
    output logic        out_eof
`ifdef SOBEL_GRAD_SAT_FLAG_EN
    ,
    output logic        out_sat
`endif
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    logic en, xfer;
    assign en       = out_ready | ~out_valid;
    assign in_ready = en;
    assign xfer     = in_valid & en;

    // ---------------- position counters ----------------
    logic [CW-1:0] col_q, col_d, cur_col;
    logic [RW-1:0] row_q, row_d, cur_row;

    always_comb begin
        // in_sof re-anchors the current pixel at (0,0)
        cur_col = in_sof ? '0 : col_q;
        cur_row = in_sof ? '0 : row_q;
        col_d   = col_q;
        row_d   = row_q;
        if (xfer) begin
            if (cur_col == CW'(IMG_W - 1)) begin
                col_d = '0;
                row_d = (cur_row == RW'(IMG_H - 1)) ? '0 : cur_row + 1'b1;
            end else begin
                col_d = cur_col + 1'b1;
                row_d = cur_row;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    // ---------------- line buffers (lb_dout[0] = row-1, [1] = row-2) -------
    pix_t lb_din  [2];
    pix_t lb_dout [2];

    assign lb_din[0] = in_pix;
    assign lb_din[1] = lb_dout[0];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_lb
            sobel_line_buf #(.DEPTH(IMG_W)) u_lb (
                .clk  (clk),
                .rst_n(rst_n),
                .we   (xfer),
                .din  (lb_din[gi]),
                .dout (lb_dout[gi])
            );
        end
    endgenerate

    // ---------------- 3x3 window: index 0 = top row, 2 = bottom row --------
    pix_t col_new [3];
    pix_t wa_q    [3];   // left column (two transfers back)
    pix_t wb_q    [3];   // centre column (one transfer back)

    assign col_new[0] = lb_dout[1];
    assign col_new[1] = lb_dout[0];
    assign col_new[2] = in_pix;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                wa_q[i] <= '0;
                wb_q[i] <= '0;
            end
        end else if (xfer) begin
            for (int i = 0; i < 3; i++) begin
                wa_q[i] <= wb_q[i];
                wb_q[i] <= col_new[i];
            end
        end
    end

    // ---------------- stage 1 inputs ----------------
    logic [10:0] sum_l, sum_r, sum_t, sum_b;
    grad_t       gx, gy;
    logic        win_ok, win_eol, win_eof;

    always_comb begin
        sum_l = 11'(wa_q[0]) + (11'(wa_q[1]) << 1) + 11'(wa_q[2]);
        sum_r = 11'(col_new[0]) + (11'(col_new[1]) << 1) + 11'(col_new[2]);
        sum_t = 11'(wa_q[0]) + (11'(wb_q[0]) << 1) + 11'(col_new[0]);
        sum_b = 11'(wa_q[2]) + (11'(wb_q[2]) << 1) + 11'(col_new[2]);
        // sums are <= 1020, so their MSB is 0 and signed subtraction is exact
        gx    = $signed(sum_r) - $signed(sum_l);
        gy    = $signed(sum_b) - $signed(sum_t);
    end

    assign win_ok  = xfer & (cur_row >= RW'(2)) & (cur_col >= CW'(2));
    assign win_eol = (cur_col == CW'(IMG_W - 1));
    assign win_eof = win_eol & (cur_row == RW'(IMG_H - 1));

    // ---------------- stage 2 / 3 combinational ----------------
    grad_t       s1_gx_q, s1_gy_q;
    logic        s1_valid_q, s1_eol_q, s1_eof_q;
    logic [19:0] s2_sqx_q, s2_sqy_q;
    logic        s2_valid_q, s2_eol_q, s2_eof_q;

    mag_t        mag_x, mag_y;
    logic [19:0] sq_x, sq_y;
    logic [20:0] sum_sq;
    logic        clamp;
    rad_t        rad_d;

    always_comb begin
        mag_x  = abs_shift(s1_gx_q, GSHIFT);
        mag_y  = abs_shift(s1_gy_q, GSHIFT);
        sq_x   = 20'(mag_x) * 20'(mag_x);
        sq_y   = 20'(mag_y) * 20'(mag_y);
        sum_sq = 21'(s2_sqx_q) + 21'(s2_sqy_q);
        clamp  = sum_sq > 21'(RAD_MAX);
        rad_d  = clamp ? RAD_MAX : sum_sq[15:0];
    end

    // ---------------- pipeline registers ----------------
    logic out_valid_q, out_eol_q, out_eof_q;
    rad_t out_rad_q;
`ifdef SOBEL_GRAD_SAT_FLAG_EN
    logic out_sat_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_gx_q     <= '0;
            s1_gy_q     <= '0;
            s1_eol_q    <= 1'b0;
            s1_eof_q    <= 1'b0;
            s2_valid_q  <= 1'b0;
            s2_sqx_q    <= '0;
            s2_sqy_q    <= '0;
            s2_eol_q    <= 1'b0;
            s2_eof_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_rad_q   <= '0;
            out_eol_q   <= 1'b0;
            out_eof_q   <= 1'b0;
`ifdef SOBEL_GRAD_SAT_FLAG_EN
            out_sat_q   <= 1'b0;
`endif
        end else if (en) begin
            s1_valid_q  <= win_ok;
            s1_gx_q     <= gx;
            s1_gy_q     <= gy;
            s1_eol_q    <= win_eol;
            s1_eof_q    <= win_eof;
            s2_valid_q  <= s1_valid_q;
            s2_sqx_q    <= sq_x;
            s2_sqy_q    <= sq_y;
            s2_eol_q    <= s1_eol_q;
            s2_eof_q    <= s1_eof_q;
            out_valid_q <= s2_valid_q;
            out_rad_q   <= rad_d;
            out_eol_q   <= s2_eol_q;
            out_eof_q   <= s2_eof_q;
`ifdef SOBEL_GRAD_SAT_FLAG_EN
            out_sat_q   <= clamp;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out_rad   = out_rad_q;
    assign out_eol   = out_eol_q;
    assign out_eof   = out_eof_q;
`ifdef SOBEL_GRAD_SAT_FLAG_EN
    assign out_sat   = out_sat_q;
`endif

endmodule

// File: tb/tb_sobel_grad_sq.sv
module tb_sobel_grad_sq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_sof = 1'b0;
    logic        out_ready = 1'b1;
    logic [7:0]  in_pix = 8'd0;

    logic        in_ready, out_valid, out_eol, out_eof;
    logic [15:0] out_rad;
    logic        in_ready0, out_valid0, out_eol0, out_eof0;
    logic [15:0] out_rad0;
`ifdef SOBEL_GRAD_SAT_FLAG_EN
    logic        out_sat, out_sat0;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    // GSHIFT=3 instance drives the handshake; GSHIFT=0 instance runs in lockstep
    sobel_grad_sq #(.IMG_W(8), .IMG_H(4), .GSHIFT(3)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_pix(in_pix), .in_sof(in_sof), .out_valid(out_valid),
        .out_ready(out_ready), .out_rad(out_rad), .out_eol(out_eol),
        .out_eof(out_eof)
`ifdef SOBEL_GRAD_SAT_FLAG_EN
        , .out_sat(out_sat)
`endif
    );

    sobel_grad_sq #(.IMG_W(8), .IMG_H(4), .GSHIFT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .in_pix(in_pix), .in_sof(in_sof), .out_valid(out_valid0),
        .out_ready(out_ready), .out_rad(out_rad0), .out_eol(out_eol0),
        .out_eof(out_eof0)
`ifdef SOBEL_GRAD_SAT_FLAG_EN
        , .out_sat(out_sat0)
`endif
    );

    // Output collector: records every accepted output
    logic [15:0] q_rad[$];
    logic [15:0] q_rad0[$];
    logic [1:0]  q_flags[$];
    logic        q_v0[$];
    logic        q_sat0[$];

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            q_rad.push_back(out_rad);
            q_rad0.push_back(out_rad0);
            q_flags.push_back({out_eol, out_eof});
            q_v0.push_back(out_valid0);
`ifdef SOBEL_GRAD_SAT_FLAG_EN
            q_sat0.push_back(out_sat0);
`else
            q_sat0.push_back(1'b0);
`endif
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    // Hand-computed model: kind 0 = flat 100, kind 1 = vertical step at col 4.
    // Output k has centre column (k%6)+1; cols 3 and 4 see Gx=1020.
    function automatic logic [15:0] exp_rad(input int kind, input int shift, input int k);
        int c;
        c = k % 6;
        if (kind == 1 && (c == 2 || c == 3))
            return (shift == 3) ? 16'd16129 : 16'hFFFF;
        return 16'd0;
    endfunction

    function automatic logic exp_sat(input int kind, input int k);
        return (kind == 1) && ((k % 6 == 2) || (k % 6 == 3));
    endfunction

    function automatic logic [7:0] pix_of(input int kind, input int i);
        if (kind == 0) return 8'd100;
        if (kind == 2) return 8'd255;
        return ((i % 8) >= 4) ? 8'd255 : 8'd0;
    endfunction

    task automatic clear_q();
        q_rad.delete(); q_rad0.delete(); q_flags.delete();
        q_v0.delete(); q_sat0.delete();
    endtask

    task automatic send_pixel(input logic [7:0] v, input logic s);
        logic acc;
        int   guard;
        acc = 1'b0;
        guard = 0;
        in_valid = 1'b1;
        in_pix = v;
        in_sof = s;
        while (!acc) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            guard++;
            if (!acc && guard > 300) begin
                tests_run++; tests_failed++;
                $display("FAIL send_pixel timeout: in_ready stuck 0 after %0d cycles", guard);
                acc = 1'b1;
            end
        end
        in_valid = 1'b0;
        in_sof = 1'b0;
    endtask

    task automatic send_frame(input int kind, input int npix, input logic sof);
        for (int i = 0; i < npix; i++)
            send_pixel(pix_of(kind, i), sof && (i == 0));
    endtask

    task automatic drain();
        repeat (20) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        tests_run++;
        if ({out_valid, out_eol, out_eof, out_rad} !== 19'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got valid=%b eol=%b eof=%b rad=%h required all 0",
                     out_valid, out_eol, out_eof, out_rad);
        end
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_in_ready: got %b required 1", in_ready);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        $display("[TB] reset checked");
    endtask

    task automatic test_const();
        clear_q();
        send_frame(0, 32, 1'b1);
        drain();
        tests_run++;
        if (q_rad.size() !== 12) begin
            tests_failed++;
            $display("FAIL const_count: got %0d required 12", q_rad.size());
        end
        for (int k = 0; k < q_rad.size() && k < 12; k++) begin
            $display("[TB] const out %0d rad=%h flags=%b", k, q_rad[k], q_flags[k]);
            tests_run++;
            if (q_rad[k] !== exp_rad(0, 3, k) || q_rad0[k] !== exp_rad(0, 0, k)) begin
                tests_failed++;
                $display("FAIL const_rad[%0d]: got %h/%h required %h/%h", k, q_rad[k], q_rad0[k],
                         exp_rad(0, 3, k), exp_rad(0, 0, k));
            end
            tests_run++;
            if (q_flags[k] !== {k % 6 == 5, k == 11}) begin
                tests_failed++;
                $display("FAIL const_flags[%0d]: got eol,eof=%b required %b", k, q_flags[k],
                         {k % 6 == 5, k == 11});
            end
        end
    endtask

    task automatic test_step();
        clear_q();
        send_frame(1, 32, 1'b1);
        drain();
        tests_run++;
        if (q_rad.size() !== 12) begin
            tests_failed++;
            $display("FAIL step_count: got %0d required 12", q_rad.size());
        end
        for (int k = 0; k < q_rad.size() && k < 12; k++) begin
            $display("[TB] step out %0d rad3=%h rad0=%h flags=%b", k, q_rad[k], q_rad0[k], q_flags[k]);
            tests_run++;
            if (q_rad[k] !== exp_rad(1, 3, k)) begin
                tests_failed++;
                $display("FAIL step_rad_shift3[%0d]: got %h required %h", k, q_rad[k], exp_rad(1, 3, k));
            end
            tests_run++;
            if (q_rad0[k] !== exp_rad(1, 0, k) || q_v0[k] !== 1'b1) begin
                tests_failed++;
                $display("FAIL step_rad_shift0[%0d]: got %h valid=%b required %h valid=1", k,
                         q_rad0[k], q_v0[k], exp_rad(1, 0, k));
            end
            tests_run++;
            if (q_flags[k] !== {k % 6 == 5, k == 11}) begin
                tests_failed++;
                $display("FAIL step_flags[%0d]: got %b required %b", k, q_flags[k], {k % 6 == 5, k == 11});
            end
`ifdef SOBEL_GRAD_SAT_FLAG_EN
            tests_run++;
            if (q_sat0[k] !== exp_sat(1, k)) begin
                tests_failed++;
                $display("FAIL step_sat[%0d]: got %b required %b", k, q_sat0[k], exp_sat(1, k));
            end
`endif
        end
    endtask

    task automatic test_stall();
        clear_q();
        fork
            send_frame(1, 32, 1'b1);
            begin
                int guard;
                guard = 0;
                do begin
                    @(posedge clk); #1;
                    guard++;
                end while (!(out_valid && q_rad.size() == 2) && guard < 300);
                if (guard >= 300) begin
                    tests_run++; tests_failed++;
                    $display("FAIL stall_setup: output 2 never pending within %0d cycles", guard);
                end
                out_ready = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    @(negedge clk);
                    tests_run++;
                    if (out_valid !== 1'b1 || out_rad !== 16'd16129 || in_ready !== 1'b0
                        || out_eol !== 1'b0) begin
                        tests_failed++;
                        $display("FAIL stall_hold[%0d]: got valid=%b rad=%h in_ready=%b eol=%b required 1/3f01/0/0",
                                 s, out_valid, out_rad, in_ready, out_eol);
                    end
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
            end
        join
        drain();
        tests_run++;
        if (q_rad.size() !== 12) begin
            tests_failed++;
            $display("FAIL stall_count: got %0d required 12", q_rad.size());
        end
        for (int k = 0; k < q_rad.size() && k < 12; k++) begin
            $display("[TB] stall out %0d rad=%h flags=%b", k, q_rad[k], q_flags[k]);
            tests_run++;
            if (q_rad[k] !== exp_rad(1, 3, k) || q_flags[k] !== {k % 6 == 5, k == 11}) begin
                tests_failed++;
                $display("FAIL stall_seq[%0d]: got rad=%h flags=%b required rad=%h flags=%b", k,
                         q_rad[k], q_flags[k], exp_rad(1, 3, k), {k % 6 == 5, k == 11});
            end
        end
    endtask

    task automatic test_reset_mid();
        send_frame(1, 13, 1'b1);
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL midreset_state: got valid=%b in_ready=%b required 0/1", out_valid, in_ready);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        clear_q();
        send_frame(1, 32, 1'b0);
        drain();
        tests_run++;
        if (q_rad.size() !== 12) begin
            tests_failed++;
            $display("FAIL midreset_count: got %0d required 12", q_rad.size());
        end
        for (int k = 0; k < q_rad.size() && k < 12; k++) begin
            $display("[TB] midreset out %0d rad=%h flags=%b", k, q_rad[k], q_flags[k]);
            tests_run++;
            if (q_rad[k] !== exp_rad(1, 3, k) || q_flags[k] !== {k % 6 == 5, k == 11}) begin
                tests_failed++;
                $display("FAIL midreset_seq[%0d]: got rad=%h flags=%b required rad=%h flags=%b", k,
                         q_rad[k], q_flags[k], exp_rad(1, 3, k), {k % 6 == 5, k == 11});
            end
        end
    endtask

    task automatic test_sof_resync();
        clear_q();
        send_frame(2, 9, 1'b1);     // abandoned partial frame, leaves counters mid-line
        send_frame(1, 32, 1'b1);    // new frame: pixel 10 of the stream carries in_sof
        drain();
        tests_run++;
        if (q_rad.size() !== 12) begin
            tests_failed++;
            $display("FAIL sof_count: got %0d required 12", q_rad.size());
        end
        for (int k = 0; k < q_rad.size() && k < 12; k++) begin
            $display("[TB] sof out %0d rad=%h flags=%b", k, q_rad[k], q_flags[k]);
            tests_run++;
            if (q_rad[k] !== exp_rad(1, 3, k) || q_flags[k] !== {k % 6 == 5, k == 11}) begin
                tests_failed++;
                $display("FAIL sof_seq[%0d]: got rad=%h flags=%b required rad=%h flags=%b", k,
                         q_rad[k], q_flags[k], exp_rad(1, 3, k), {k % 6 == 5, k == 11});
            end
        end
    endtask

    initial begin
        test_reset();
        test_const();
        test_step();
        test_stall();
        test_reset_mid();
        test_sof_resync();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
